// File: rtl/capture_seq.sv
// Triggered frame capture sequencer: watches an 8-bit ADC stream for a level crossing,
// then writes a decimated frame of 2^ADDR_W samples into an external capture RAM.
module capture_seq #(
    parameter int unsigned ADDR_W  = 9,
    parameter logic [19:0] AUTO_TO = 20'd500000,
    parameter logic [15:0] HOLDOFF = 16'd1024
) (
    input  logic              clk_ad,
    input  logic              rst_dp,
    input  logic [7:0]        ad_data,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic [1:0]        trig_mode,
    input  logic [2:0]        decim,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              trig_forced
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ad_data_r_q;
    logic              prev_valid_q;
    logic [19:0]       to_cnt_q, to_cnt_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [6:0]        dec_cnt_q, dec_cnt_d;
    logic [2:0]        decim_q, decim_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              frame_done_q, frame_done_d;
    logic              trig_forced_q, trig_forced_d;
    logic              busy_q, busy_d;

    logic       mode_auto, mode_single;
    logic       rise_evt, fall_evt, trig_evt, timeout;
    logic [7:0] dec_span;
    logic [6:0] dec_mask;
    logic       wr_fire, frame_end, hold_end, trig_take;

    assign mode_auto   = (trig_mode == 2'b00);
    assign mode_single = (trig_mode == 2'b10);

    assign rise_evt = prev_valid_q && (ad_data_r_q < trig_level) && (ad_data >= trig_level);
    assign fall_evt = prev_valid_q && (ad_data_r_q > trig_level) && (ad_data <= trig_level);
    assign trig_evt = trig_edge ? fall_evt : rise_evt;
    // >= rather than == so a counter that ran on in normal mode fires at once if auto is selected.
    assign timeout  = mode_auto && (to_cnt_q >= AUTO_TO - 20'd1);

    assign dec_span = 8'd1 << decim_q;
    assign dec_mask = 7'(dec_span - 8'd1);
    assign wr_fire  = (state_q == S_CAPT) && (dec_cnt_q == 7'd0);
    // The frame closes at the end of the decimation period holding the last write,
    // so every frame occupies exactly 2^ADDR_W * 2^decim cycles.
    assign frame_end = (state_q == S_CAPT) && (dec_cnt_q == dec_mask) &&
                       (last_q || (wr_fire && (&addr_q)));
    assign hold_end  = (hold_cnt_q == HOLDOFF - 16'd1);
    assign trig_take = (state_q == S_WAIT) && (state_d == S_CAPT);

    // State register
    always_ff @(posedge clk_ad) begin
        if (rst_dp) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!mode_single || arm) state_d = S_WAIT;
            S_WAIT: if (trig_evt || timeout) state_d = S_CAPT;
            S_CAPT: if (frame_end) state_d = S_HOLD;
            S_HOLD: if (hold_end) state_d = mode_single ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and latched trigger context
    always_comb begin
        to_cnt_d      = 20'd0;
        hold_cnt_d    = 16'd0;
        dec_cnt_d     = 7'd0;
        addr_d        = '0;
        last_d        = 1'b0;
        decim_d       = decim_q;
        trig_forced_d = trig_forced_q;
        frame_done_d  = frame_end;
        busy_d        = (state_d == S_CAPT);

        if (state_q == S_WAIT && state_d == S_WAIT) begin
            to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 20'd1;
        end
        if (state_q == S_HOLD && state_d == S_HOLD) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end
        if (state_q == S_CAPT) begin
            dec_cnt_d = (dec_cnt_q == dec_mask) ? 7'd0 : dec_cnt_q + 7'd1;
            addr_d    = wr_fire ? addr_q + 1'b1 : addr_q;
            last_d    = last_q || (wr_fire && (&addr_q));
        end
        if (state_d != S_CAPT) begin
            dec_cnt_d = 7'd0;
            last_d    = 1'b0;
        end
        // A real event wins over a coincident timeout.
        if (trig_take) begin
            decim_d       = decim;
            trig_forced_d = !trig_evt;
        end
    end

    always_ff @(posedge clk_ad) begin
        if (rst_dp) begin
            ad_data_r_q   <= 8'd0;
            prev_valid_q  <= 1'b0;
            to_cnt_q      <= 20'd0;
            hold_cnt_q    <= 16'd0;
            dec_cnt_q     <= 7'd0;
            decim_q       <= 3'd0;
            addr_q        <= '0;
            last_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            trig_forced_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            ad_data_r_q   <= ad_data;
            prev_valid_q  <= 1'b1;
            to_cnt_q      <= to_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            dec_cnt_q     <= dec_cnt_d;
            decim_q       <= decim_d;
            addr_q        <= addr_d;
            last_q        <= last_d;
            frame_done_q  <= frame_done_d;
            trig_forced_q <= trig_forced_d;
            busy_q        <= busy_d;
        end
    end

    // Output decode
    always_comb begin
        wr_en       = wr_fire;
        wr_addr     = addr_q;
        wr_data     = (state_q == S_CAPT) ? ad_data_r_q : 8'd0;
        frame_done  = frame_done_q;
        busy        = busy_q;
        trig_forced = trig_forced_q;
    end

endmodule

// File: tb/tb_capture_seq.sv
// Directed bench for capture_seq: vector table for the trigger path plus hand-written
// multi-cycle sequences for frame length, auto timeout, single mode, decimation and reset.
module tb_capture_seq;
  localparam int ADDR_W = 9;

  logic              clk_ad = 1'b0;
  logic              rst_dp;
  logic [7:0]        ad_data;
  logic [7:0]        trig_level;
  logic              trig_edge;
  logic [1:0]        trig_mode;
  logic [2:0]        decim;
  logic              arm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic              busy;
  logic              trig_forced;

  capture_seq #(.ADDR_W(ADDR_W), .AUTO_TO(20'd100), .HOLDOFF(16'd16)) dut (
    .clk_ad(clk_ad), .rst_dp(rst_dp), .ad_data(ad_data), .trig_level(trig_level),
    .trig_edge(trig_edge), .trig_mode(trig_mode), .decim(decim), .arm(arm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .busy(busy), .trig_forced(trig_forced)
  );

  // clock / reset
  always #5 clk_ad = ~clk_ad;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // scoreboard / monitor
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  bit sb_on = 0;
  int cyc = 0, n_wr = 0, n_busy = 0, n_fd = 0;
  int gap_err = 0, addr_err = 0, data_err = 0, exp_gap = 1;
  int last_wr_cyc = -1, last_wr_addr = 0, fd_gap = 0, fd_last_addr = 0;

  always @(negedge clk_ad) begin
    cyc++;
    if (busy) n_busy++;
    if (frame_done) begin
      n_fd++;
      fd_gap = cyc - last_wr_cyc;
      fd_last_addr = last_wr_addr;
    end
    if (wr_en) begin
      if (n_wr > 0 && (cyc - last_wr_cyc) != exp_gap) gap_err++;
      if (wr_addr != 9'(n_wr)) addr_err++;
      if (sb_on) begin
        if (exp_q.size() == 0) data_err++;
        else begin
          exp_v = exp_q.pop_front();
          if (wr_data !== exp_v) data_err++;
        end
      end
      n_wr++;
      last_wr_cyc = cyc;
      last_wr_addr = int'(wr_addr);
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk_ad);
    #1;
  endtask

  task automatic clear_mon();
    n_wr = 0; n_busy = 0; n_fd = 0; gap_err = 0; addr_err = 0; data_err = 0;
    exp_gap = 1; last_wr_cyc = -1; fd_gap = 0; fd_last_addr = 0; sb_on = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [7:0] d);
    rst_dp = 1'b1; arm = 1'b0; ad_data = d;
    tick(); tick();
    rst_dp = 1'b0;
    clear_mon();
  endtask

  task automatic run_to_frame_done(input int budget, input string name);
    int c;
    for (c = 0; c < budget; c++) begin
      tick();
      if (n_fd > 0) break;
    end
    check({name, "_frame_done_seen"}, 32'(c < budget), 32'd1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [1:0] exp_state;
    logic       exp_wr_en;
    logic       exp_busy;
    logic [8:0] exp_addr;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int val, hold_n, wait_n, c;

    vecs[0] = '{8'd130, 2'd1, 1'b0, 1'b0, 9'd0, 8'd0};
    vecs[1] = '{8'd120, 2'd1, 1'b0, 1'b0, 9'd0, 8'd0};
    vecs[2] = '{8'd127, 2'd1, 1'b0, 1'b0, 9'd0, 8'd0};
    vecs[3] = '{8'd128, 2'd2, 1'b1, 1'b1, 9'd0, 8'd128};
    vecs[4] = '{8'd129, 2'd2, 1'b1, 1'b1, 9'd1, 8'd129};
    vecs[5] = '{8'd130, 2'd2, 1'b1, 1'b1, 9'd2, 8'd130};

    // ---- normal mode, rising 128, ramp, decim 0
    trig_level = 8'd128; trig_edge = 1'b0; trig_mode = 2'b01; decim = 3'd0;
    do_reset(8'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_trig_forced", 32'(trig_forced), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    for (int n = 0; n < 512; n++) exp_q.push_back((128 + n > 200) ? 8'd200 : 8'(128 + n));
    sb_on = 1;
    foreach (vecs[i]) begin
      ad_data = vecs[i].din;
      tick();
      check($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr_en));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_wdata", i), 32'(wr_data), 32'(vecs[i].exp_wdata));
    end
    val = 131;
    for (c = 0; c < 700; c++) begin
      ad_data = (val > 200) ? 8'd200 : 8'(val);
      val++;
      tick();
      if (n_fd > 0) break;
    end
    check("ramp_frame_done_seen", 32'(c < 700), 32'd1);
    check("ramp_writes", 32'(n_wr), 32'd512);
    check("ramp_busy_cycles", 32'(n_busy), 32'd512);
    check("ramp_gap_err", 32'(gap_err), 32'd0);
    check("ramp_addr_err", 32'(addr_err), 32'd0);
    check("ramp_data_err", 32'(data_err), 32'd0);
    check("ramp_fd_after_last", 32'(fd_gap), 32'd1);
    check("ramp_fd_last_addr", 32'(fd_last_addr), 32'd511);
    check("ramp_fd_addr_zero", 32'(wr_addr), 32'd0);
    check("ramp_fd_state", 32'(dut.state_q), 32'd3);
    hold_n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dut.state_q == 2'd3) hold_n++;
      else break;
    end
    check("holdoff_len", 32'(hold_n), 32'd16);
    check("holdoff_to_wait", 32'(dut.state_q), 32'd1);
    check("frame_done_once", 32'(n_fd), 32'd1);

    // ---- auto mode timeout with constant input
    trig_mode = 2'b00;
    do_reset(8'd50);
    wait_n = 0;
    for (c = 0; c < 300; c++) begin
      tick();
      if (busy) break;
      if (dut.state_q == 2'd1) wait_n++;
    end
    check("auto_capture_seen", 32'(busy), 32'd1);
    check("auto_wait_cycles", 32'(wait_n), 32'd100);
    check("auto_trig_forced", 32'(trig_forced), 32'd1);
    check("auto_first_wdata", 32'(wr_data), 32'd50);

    // ---- auto mode, event coincides with timeout
    do_reset(8'd50);
    wait_n = 0;
    for (c = 0; c < 300; c++) begin
      ad_data = (c == 100) ? 8'd128 : 8'd50;
      tick();
      if (busy) break;
      if (dut.state_q == 2'd1) wait_n++;
    end
    check("coinc_capture_seen", 32'(busy), 32'd1);
    check("coinc_wait_cycles", 32'(wait_n), 32'd100);
    check("coinc_trig_forced", 32'(trig_forced), 32'd0);
    check("coinc_first_wdata", 32'(wr_data), 32'd128);

    // ---- trig_level 0 rising: normal waits forever, auto still times out
    trig_mode = 2'b01; trig_level = 8'd0;
    do_reset(8'd0);
    for (int k = 0; k < 300; k++) begin
      ad_data = 8'($urandom_range(0, 255));
      tick();
    end
    check("lvl0_normal_writes", 32'(n_wr), 32'd0);
    check("lvl0_normal_state", 32'(dut.state_q), 32'd1);
    trig_mode = 2'b00;
    tick();
    check("lvl0_auto_busy", 32'(busy), 32'd1);
    check("lvl0_auto_forced", 32'(trig_forced), 32'd1);

    // ---- single mode
    trig_mode = 2'b10; trig_level = 8'd128;
    do_reset(8'd100);
    for (int k = 0; k < 20; k++) begin
      ad_data = k[0] ? 8'd130 : 8'd100;
      tick();
    end
    check("single_noarm_writes", 32'(n_wr), 32'd0);
    check("single_noarm_state", 32'(dut.state_q), 32'd0);
    arm = 1'b1; ad_data = 8'd100;
    tick();
    arm = 1'b0;
    check("single_armed_state", 32'(dut.state_q), 32'd1);
    for (int k = 0; k < 10 && !busy; k++) begin
      ad_data = k[0] ? 8'd100 : 8'd130;
      tick();
    end
    check("single_capture_start", 32'(busy), 32'd1);
    run_to_frame_done(700, "single");
    for (int k = 0; k < 20; k++) begin
      ad_data = k[0] ? 8'd130 : 8'd100;
      tick();
    end
    check("single_frame_writes", 32'(n_wr), 32'd512);
    check("single_back_idle", 32'(dut.state_q), 32'd0);
    clear_mon();
    for (int k = 0; k < 50; k++) begin
      ad_data = k[0] ? 8'd130 : 8'd100;
      tick();
    end
    check("single_no_rearm_writes", 32'(n_wr), 32'd0);
    arm = 1'b1; ad_data = 8'd100;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 10 && !busy; k++) begin
      ad_data = k[0] ? 8'd100 : 8'd130;
      tick();
    end
    check("single_rearm_capture", 32'(busy), 32'd1);

    // ---- decim 2, falling, level 100, decim changed mid-frame
    trig_mode = 2'b01; trig_edge = 1'b1; trig_level = 8'd100; decim = 3'd2;
    do_reset(8'd150);
    exp_gap = 4;
    for (int n = 0; n < 512; n++) exp_q.push_back(8'd100);
    sb_on = 1;
    tick(); tick();
    ad_data = 8'd100;
    tick();
    check("dec_trig_busy", 32'(busy), 32'd1);
    check("dec_first_wr_en", 32'(wr_en), 32'd1);
    check("dec_first_wdata", 32'(wr_data), 32'd100);
    for (c = 0; c < 2200; c++) begin
      if (c == 100) decim = 3'd0;
      tick();
      if (n_fd > 0) break;
    end
    check("dec_frame_done_seen", 32'(c < 2200), 32'd1);
    check("dec_writes", 32'(n_wr), 32'd512);
    check("dec_gap_err", 32'(gap_err), 32'd0);
    check("dec_addr_err", 32'(addr_err), 32'd0);
    check("dec_data_err", 32'(data_err), 32'd0);
    check("dec_busy_cycles", 32'(n_busy), 32'd2048);
    check("dec_fd_gap", 32'(fd_gap), 32'd4);
    check("dec_fd_last_addr", 32'(fd_last_addr), 32'd511);

    // ---- reset mid-capture at addr 200 after a forced trigger
    trig_mode = 2'b00; trig_edge = 1'b0; trig_level = 8'd128; decim = 3'd0;
    do_reset(8'd50);
    for (c = 0; c < 400; c++) begin
      tick();
      if (wr_en && wr_addr == 9'd200) break;
    end
    check("midrst_reached_200", 32'(wr_addr), 32'd200);
    check("midrst_forced_before", 32'(trig_forced), 32'd1);
    rst_dp = 1'b1; trig_mode = 2'b01;
    tick();
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_trig_forced", 32'(trig_forced), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'd0);
    rst_dp = 1'b0;
    tick();
    check("midrst_rewait", 32'(dut.state_q), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/capture_seq.md
CAPTURE_SEQ -- requirements
Module: capture_seq

Interface
REQ-001 SHALL take parameters as: name, default, meaning.
- ADDR_W, 9, capture RAM address width; frame depth is 2^ADDR_W = 512 samples.
- AUTO_TO, 20'd500000, auto-mode trigger timeout in clk_ad cycles.
- HOLDOFF, 16'd1024, dead time in cycles between end of frame and re-arm.
REQ-002 SHALL have ports as: name, direction, width, meaning.
- clk_ad, in, 1, sample clock; the only clock.
- rst_dp, in, 1, synchronous active-high reset.
- ad_data, in, 8, ADC sample.
- trig_level, in, 8, trigger threshold.
- trig_edge, in, 1, 0 = rising, 1 = falling.
- trig_mode, in, 2, 00 auto, 01 normal, 10 single, 11 treated as normal.
- decim, in, 3, store 1 of every 2^decim samples.
- arm, in, 1, single-shot re-arm pulse.
- wr_en, out, 1, capture RAM write strobe.
- wr_addr, out, ADDR_W, capture RAM write address.
- wr_data, out, 8, capture RAM write data.
- frame_done, out, 1, one-cycle end-of-frame pulse.
- busy, out, 1, high while in CAPTURE.
- trig_forced, out, 1, last frame was started by timeout.
REQ-003 SHALL use one clock and a synchronous active-high reset: clk_ad, rst_dp.

Function
REQ-004 SHALL register ad_data into ad_data_r every cycle, and SHALL set prev_valid one cycle after reset release.
REQ-005 SHALL detect a rising event when prev_valid && ad_data_r < trig_level && ad_data >= trig_level.
REQ-006 SHALL detect a falling event when prev_valid && ad_data_r > trig_level && ad_data <= trig_level.
REQ-007 SHALL implement the states IDLE, WAIT_TRIG, CAPTURE, HOLDOFF, and SHALL enter IDLE on reset.
REQ-008 IDLE SHALL go to WAIT_TRIG next cycle when trig_mode != 10, or when trig_mode == 10 and arm = 1.
REQ-009 WAIT_TRIG SHALL run a 20-bit timeout counter, cleared on entry.
- A trigger event SHALL cause transition to CAPTURE with trig_forced <= 0.
- In auto mode, counter == AUTO_TO-1 with no event SHALL cause transition to CAPTURE with trig_forced <= 1.
REQ-010 If an event and the timeout coincide, it SHALL be a real trigger (trig_forced = 0).
REQ-011 SHALL latch decim on the trigger cycle; decim changes mid-frame SHALL be ignored.
REQ-012 In CAPTURE, wr_data SHALL equal ad_data_r, so the sample at the trigger cycle is written at wr_addr 0 on the first CAPTURE cycle.
REQ-013 In CAPTURE, wr_en SHALL be 1 when the decimation counter is 0.
- The decimation counter SHALL be cleared on entry and count modulo 2^decim.
- wr_en SHALL be 0 in every other state.
REQ-014 wr_addr SHALL increment by 1 after each write; the write at address 2^ADDR_W-1 SHALL be the last of the frame.
REQ-015 The cycle after the last write SHALL enter HOLDOFF with frame_done = 1 for exactly that cycle, and wr_addr SHALL return to 0.
REQ-016 HOLDOFF SHALL last exactly HOLDOFF cycles, then go to IDLE if trig_mode == 10, else to WAIT_TRIG.
REQ-017 arm SHALL be ignored outside IDLE.
REQ-018 A mode change SHALL take effect only at the next decision point; switching to single while in WAIT_TRIG keeps the block armed.
REQ-019 busy SHALL equal (state == CAPTURE), registered.
REQ-020 trig_forced SHALL hold its value until the next trigger.
REQ-021 With trig_level = 0 and rising edge selected, no event is possible; auto mode SHALL still capture via timeout, and normal mode SHALL wait indefinitely.
REQ-022 Frame length SHALL be 512 × 2^decim cycles (decim = 0: 512; decim = 7: 65536).

Reset
REQ-023 rst_dp high at a clk_ad edge SHALL force the following after that edge, including mid-CAPTURE:
- state IDLE.
- wr_en 0, wr_addr 0, wr_data 0.
- frame_done 0, busy 0, trig_forced 0.
- prev_valid 0, and all counters 0.
REQ-024 The first cycle after reset release SHALL NOT produce a trigger event.

Verification
REQ-025 Normal mode, rising, trig_level = 128, ramp 120→200 step 1, decim = 0:
- first write has wr_data = 128 at addr 0.
- 512 consecutive wr_en cycles.
- frame_done pulses once, on the cycle after the addr-511 write.
REQ-026 Auto mode, constant ad_data = 50, AUTO_TO = 100:
- CAPTURE is entered 100 cycles after WAIT_TRIG entry.
- trig_forced = 1.
REQ-027 Single mode:
- one frame is captured, then the block returns to IDLE.
- a second crossing with no arm produces no writes.
- an arm pulse re-arms, and the next crossing captures.
REQ-028 decim = 2, falling, trig_level = 100:
- wr_en every 4th cycle.
- changing decim to 0 mid-frame does not alter the spacing.
- the frame spans 2048 cycles.
REQ-029 Reset asserted at wr_addr = 200:
- next cycle wr_en = 0, wr_addr = 0, state IDLE.
- with trig_mode = 01, WAIT_TRIG is re-entered after release.
REQ-030 Auto mode, with the event and the timeout on the same cycle: trig_forced = 0.
